// File: rtl/display_pkg.sv
// Shared types and glyph data for the result display driver.
// Glyphs are stored active-high; bit0 = segment a .. bit6 = segment g.
`timescale 1ns/1ps
package display_pkg;

    typedef enum logic [1:0] {IDLE, CONV, UPD} state_t;

    localparam int BCD_DIGITS = 5;
    localparam int MAG_W      = 15;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // Index 15 first so HEX_GLYPH[n] selects the glyph for nibble n.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble-to-glyph decoder, active-high; zero latency, no handshake.
// Blank has priority over minus, which has priority over the nibble glyph.
`timescale 1ns/1ps
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_GLYPH[nibble];
        if (blank) begin
            seg = SEG_BLANK;
        end else if (minus) begin
            seg = SEG_MINUS;
        end
    end

endmodule

// File: rtl/result_display_driver.sv
// Captures a sign-magnitude product, converts it to BCD over 15 cycles and drives eight 7-segment digits.
// Latency: valid at edge N -> segments at N+16, done during the next cycle; never stalls, one-deep pending slot.
`timescale 1ns/1ps
module result_display_driver
    import display_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        result_valid,
    input  logic [15:0] result,
    input  logic [7:0]  op_value,
    input  logic        disp_hex,
    output logic        busy,
    output logic        done,
    output logic [6:0]  ssegment0,
    output logic [6:0]  ssegment1,
    output logic [6:0]  ssegment2,
    output logic [6:0]  ssegment3,
    output logic [6:0]  ssegment4,
    output logic [6:0]  ssegment5,
    output logic [6:0]  ssegment6,
    output logic [6:0]  ssegment7
);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    state_t                 state_q, state_d;
    logic                   start_conv;
    logic [15:0]            start_res;
    logic [7:0]             start_op;
    logic [3:0]             cnt_q;
    logic [MAG_W-1:0]       shift_q;
    logic [4*BCD_DIGITS-1:0] bcd_q, bcd_adj;
    logic [15:0]            cap_res_q, pend_res_q;
    logic [7:0]             cap_op_q, pend_op_q;
    logic                   pend_q, hex_shown_q, done_q;
    logic [7:0][3:0]        dig_nib;
    logic [7:0]             dig_blank, dig_minus;
    logic                   seen_nz;
    logic [7:0][6:0]        dec_seg, seg_q;

    // A fresh pulse overrides older pending data.
    assign start_res = result_valid ? result : pend_res_q;
    assign start_op  = result_valid ? op_value : pend_op_q;

    always_comb begin
        state_d    = state_q;
        start_conv = 1'b0;
        case (state_q)
            IDLE: begin
                if (result_valid) begin
                    state_d    = CONV;
                    start_conv = 1'b1;
                end else if (disp_hex != hex_shown_q) begin
                    state_d = UPD;
                end
            end
            CONV: begin
                if (cnt_q == 4'd0) begin
                    state_d = UPD;
                end
            end
            UPD: begin
                if (result_valid || pend_q) begin
                    state_d    = CONV;
                    start_conv = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            bcd_q      <= '0;
            cap_res_q  <= '0;
            cap_op_q   <= '0;
            pend_q     <= 1'b0;
            pend_res_q <= '0;
            pend_op_q  <= '0;
        end else begin
            if (start_conv) begin
                cap_res_q <= start_res;
                cap_op_q  <= start_op;
                shift_q   <= start_res[MAG_W-1:0];
                bcd_q     <= '0;
                cnt_q     <= 4'd14;
                pend_q    <= 1'b0;
            end else begin
                if (state_q == CONV) begin
                    bcd_q   <= {bcd_adj[4*BCD_DIGITS-2:0], shift_q[MAG_W-1]};
                    shift_q <= {shift_q[MAG_W-2:0], 1'b0};
                    cnt_q   <= cnt_q - 4'd1;
                end
                if (result_valid) begin
                    pend_q     <= 1'b1;
                    pend_res_q <= result;
                    pend_op_q  <= op_value;
                end
            end
        end
    end

    // Digit selection reads only settled state: bcd_q is complete whenever UPD samples it.
    always_comb begin
        dig_nib   = '0;
        dig_blank = '0;
        dig_minus = '0;
        seen_nz   = 1'b0;
        dig_nib[7] = cap_op_q[7:4];
        dig_nib[6] = cap_op_q[3:0];
        if (disp_hex) begin
            for (int i = 0; i < 4; i++) begin
                dig_nib[i] = cap_res_q[4*i +: 4];
            end
            dig_blank[5:4] = 2'b11;
        end else begin
            for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
                dig_nib[i]   = bcd_q[4*i +: 4];
                seen_nz      = seen_nz | (bcd_q[4*i +: 4] != 4'd0);
                dig_blank[i] = BLANK_LEADING && !seen_nz && (i != 0);
            end
            dig_minus[5] = cap_res_q[15] && (cap_res_q[MAG_W-1:0] != '0);
            dig_blank[5] = !dig_minus[5];
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_dec
        seg7_decoder u_dec (
            .nibble (dig_nib[g]),
            .blank  (dig_blank[g]),
            .minus  (dig_minus[g]),
            .seg    (dec_seg[g])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_q       <= {8{SEG_OFF}};
            hex_shown_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == UPD);
            if (state_q == UPD) begin
                seg_q       <= SEG_ACTIVE_LOW ? ~dec_seg : dec_seg;
                hex_shown_q <= disp_hex;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ssegment0 = seg_q[0];
    assign ssegment1 = seg_q[1];
    assign ssegment2 = seg_q[2];
    assign ssegment3 = seg_q[3];
    assign ssegment4 = seg_q[4];
    assign ssegment5 = seg_q[5];
    assign ssegment6 = seg_q[6];
    assign ssegment7 = seg_q[7];

endmodule
